jtcop_obj_linebuf: RTL
======================

// Module: jtcop_obj_linebuf
// PURPOSE
// Double-buffered object line buffer: the sprite draw engine writes one line while the other is scanned out.
// - Scanned pixels are presented as obj_pxl to jtcop_colmix.
// - Each scanned entry is erased behind the beam, so the next draw starts from a blank line.
// - Sits between the object draw engine (upstream) and jtcop_colmix (downstream).
// PARAMETERS
// AW    9   line address width; 2**AW pixels per half (512)
// DW    8   pixel width {palette[7:4], colour[3:0]}; colour 0 = transparent
// PORTS
// clk         in   1    video clock; all logic on posedge
// rst         in   1    synchronous, active-high reset
// pxl_cen     in   1    pixel clock enable; never asserted on two consecutive clk
// LHBL        in   1    horizontal blank, active low
// hdump       in   AW   horizontal scan position
// flip        in   1    screen flip; scan address becomes ~hdump
// line_start  out  1    one-clk pulse when the halves swap (draw engine starts a new line)
// busy        out  1    high during the post-reset clear
// buf_addr    in   AW   draw-side pixel address
// buf_din     in   DW   draw-side pixel data
// buf_we      in   1    draw-side write strobe, one pixel per clk
// obj_pxl     out  DW   pixel to colmix (its obj_pxl input)
// BEHAVIOUR
// Reset values: bank=0, obj_pxl=0, line_start=0, busy=1, FSM=CLEAR, clr_addr=0.
// FSM CLEAR
// - Walks clr_addr over all 2**(AW+1) entries, writing 0 on the scan port, one entry per clk.
// - buf_we is ignored; obj_pxl is held at 0.
// - After the last entry: -> RUN, busy=0.
// - rst asserted in any state restarts CLEAR from 0.
// FSM RUN
// - Swap: LHBL registered on every clk; a 1->0 edge toggles bank and pulses line_start in the same clk.
// - Draw port writes half ~bank at buf_addr when buf_we && buf_din[3:0]!=0. Transparent writes are dropped.
// - Later writes to the same address overwrite earlier ones. The draw engine orders objects so that the highest priority is written last.
// - A write in the swap clk uses the pre-toggle bank, i.e. it lands in the half that becomes the scan half.
// - Scan port, when pxl_cen && LHBL: read half bank at (flip ? ~hdump : hdump); latch that address.
// - Next clk (erase slot):
//   - obj_pxl <= RAM q;
//   - write 0 to the latched address in half bank.
//   - The pxl_cen spacing rule guarantees this slot never collides with the next read.
// - pxl_cen && !LHBL: obj_pxl <= 0 and no erase. Blank-period scan never corrupts the line being drawn.
// - Latency: obj_pxl is valid 1 clk after the sampling pxl_cen, i.e. one pixel behind hdump. Game top offsets hdump by 1 to align with the tile layers.
// - Draw and scan ports always address different halves, except during the swap clk (covered above), so there are no RAM write conflicts.
// - Addresses wrap modulo 2**AW; no bounds check. hdump beyond the visible width reads and erases normally.
// - RAM is the memory-of-record; obj_pxl is registered, not combinational from q.
// STRUCTURE
// Shared package jtcop_pkg:
// - localparams OBJ_AW=9, OBJ_DW=8
// - FSM state encoding {CLEAR, RUN}
// Sub-module: one jtframe_dual_ram (aw=AW+1, dw=DW).
// - Port 0 = draw {~bank, buf_addr}.
// - Port 1 = scan/erase/clear {bank, scan_addr}, or clr_addr during CLEAR.
// Control (edge detect, FSM, erase slot) stays in this module.
// TESTING
// 1 rst 1 clk, release -> busy=1 for exactly 1024 clk, then busy=0; every scanned pixel afterwards reads 0.
// 2 Write addr 5 = 8'h3A, toggle LHBL 1->0 -> line_start pulses once; scan with hdump=5 gives obj_pxl=8'h3A 1 clk after pxl_cen.
// 3 Same line rescanned after the next swap (no new writes) -> obj_pxl=0 at hdump=5, proving erase.
// 4 Write addr 7 = 8'h40 (transparent), then 8'h21, then 8'h5F -> scanned value 8'h5F.
// 5 flip=1, write addr 9'h1FE = 8'h11, scan hdump=1 -> obj_pxl=8'h11; other addresses stay 0.
// 6 Assert rst mid-line while writing -> CLEAR restarts at 0, buf_we ignored, obj_pxl=0 until busy falls.

Source files
------------

// File: rtl/jtcop_pkg.sv
// rtl/jtcop_pkg.sv - shared object line buffer constants and FSM encoding
// Contents:
//   OBJ_AW      line address width (pixels per half = 2**OBJ_AW)
//   OBJ_DW      pixel width {palette[7:4], colour[3:0]}
//   obj_state_e line buffer controller states

package jtcop_pkg;

    localparam int OBJ_AW = 9;
    localparam int OBJ_DW = 8;

    // CLEAR wipes the whole RAM after reset, RUN is normal draw/scan operation
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } obj_state_e;

    // Colour nibble 0 marks a transparent pixel that must never reach the RAM
    function automatic logic is_opaque(input logic [3:0] colour);
        return colour != 4'd0;
    endfunction

endpackage

// File: rtl/jtcop_obj_linebuf_if.sv
// rtl/jtcop_obj_linebuf_if.sv - draw engine to line buffer pixel write bus
// Signals:
//   buf_addr  draw-side pixel address within the line
//   buf_din   pixel data {palette, colour}
//   buf_we    one pixel write per clk
// Modports:
//   master    draw engine (drives the bus)
//   slave     line buffer (receives the bus)

interface jtcop_obj_linebuf_if
    import jtcop_pkg::*;
#(
    parameter int AW = OBJ_AW,
    parameter int DW = OBJ_DW
) ();

    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_din;
    logic          buf_we;

    modport master (
        output buf_addr,
        output buf_din,
        output buf_we
    );

    modport slave (
        input  buf_addr,
        input  buf_din,
        input  buf_we
    );

endinterface

// File: rtl/jtframe_dual_ram.sv
// rtl/jtframe_dual_ram.sv - two-port synchronous RAM, write-only port 0, read/write port 1
// Ports:
//   clk        clock, all accesses on posedge
//   addr0_i    port 0 address
//   data0_i    port 0 write data
//   we0_i      port 0 write enable
//   addr1_i    port 1 address
//   data1_i    port 1 write data
//   we1_i      port 1 write enable
//   q1_o       port 1 registered read data (old contents on a same-clk write)

module jtframe_dual_ram #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic [AW-1:0] addr0_i,
    input  logic [DW-1:0] data0_i,
    input  logic          we0_i,
    input  logic [AW-1:0] addr1_i,
    input  logic [DW-1:0] data1_i,
    input  logic          we1_i,
    output logic [DW-1:0] q1_o
);

    logic [DW-1:0] mem_q [0:(2**AW)-1];

    // The line buffer controller keeps the two ports on different halves,
    // so the two writes never target the same entry in one clk.
    always_ff @(posedge clk) begin
        if (we0_i) begin
            mem_q[addr0_i] <= data0_i;
        end
        if (we1_i) begin
            mem_q[addr1_i] <= data1_i;
        end
        q1_o <= mem_q[addr1_i];
    end

endmodule

// File: rtl/jtcop_obj_linebuf.sv
// rtl/jtcop_obj_linebuf.sv - double-buffered object line buffer with erase-behind-beam scan
// Ports:
//   clk         video clock
//   rst         synchronous active-high reset; restarts the RAM clear
//   pxl_cen     pixel clock enable, never high on two consecutive clk
//   LHBL        horizontal blank, active low; its falling edge swaps halves
//   hdump       horizontal scan position
//   flip        screen flip, scan address becomes ~hdump
//   line_start  one-clk pulse in the clk the halves swap
//   busy        high while the RAM is being cleared after reset
//   draw        pixel write bus from the object draw engine
//   obj_pxl     registered scanned pixel towards the colour mixer

module jtcop_obj_linebuf
    import jtcop_pkg::*;
#(
    parameter int AW = OBJ_AW,
    parameter int DW = OBJ_DW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pxl_cen,
    input  logic                 LHBL,
    input  logic [AW-1:0]        hdump,
    input  logic                 flip,
    output logic                 line_start,
    output logic                 busy,
    jtcop_obj_linebuf_if.slave   draw,
    output logic [DW-1:0]        obj_pxl
);

    localparam logic [AW:0] CLR_LAST = {(AW+1){1'b1}};

    obj_state_e    state_q, state_d;
    logic [AW:0]   clr_addr_q, clr_addr_d;
    logic          bank_q, bank_d;
    logic          lhbl_q;
    logic          line_start_q, line_start_d;
    logic          erase_q, erase_d;
    logic [AW:0]   erase_addr_q, erase_addr_d;
    logic [DW-1:0] obj_pxl_q, obj_pxl_d;

    logic [AW-1:0] scan_addr;
    logic [AW:0]   ram_addr0;
    logic          ram_we0;
    logic [AW:0]   ram_addr1;
    logic          ram_we1;
    logic [DW-1:0] ram_q;

    assign scan_addr = flip ? ~hdump : hdump;

    // The draw side always targets the half not being scanned. In the swap
    // clk bank_q still holds the old value, so such a write lands in the
    // half that is about to become the scan half.
    assign ram_addr0 = {~bank_q, draw.buf_addr};

    // LHBL history is kept even while clearing so that leaving CLEAR with
    // LHBL low does not fake a falling edge.
    always_ff @(posedge clk) begin
        lhbl_q <= LHBL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= CLEAR;
            clr_addr_q   <= '0;
            bank_q       <= 1'b0;
            line_start_q <= 1'b0;
            erase_q      <= 1'b0;
            erase_addr_q <= '0;
            obj_pxl_q    <= '0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            bank_q       <= bank_d;
            line_start_q <= line_start_d;
            erase_q      <= erase_d;
            erase_addr_q <= erase_addr_d;
            obj_pxl_q    <= obj_pxl_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        bank_d       = bank_q;
        line_start_d = 1'b0;
        erase_d      = 1'b0;
        erase_addr_d = erase_addr_q;
        obj_pxl_d    = obj_pxl_q;
        ram_we0      = 1'b0;
        ram_addr1    = {bank_q, scan_addr};
        ram_we1      = 1'b0;

        case (state_q)
            CLEAR: begin
                // One entry per clk across both halves; draw writes are ignored
                ram_addr1  = clr_addr_q;
                ram_we1    = 1'b1;
                obj_pxl_d  = '0;
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == CLR_LAST) begin
                    state_d = RUN;
                end
            end

            RUN: begin
                ram_we0 = draw.buf_we && is_opaque(draw.buf_din[3:0]);

                if (lhbl_q && !LHBL) begin
                    bank_d       = ~bank_q;
                    line_start_d = 1'b1;
                end

                if (erase_q) begin
                    // The read issued last clk is now on ram_q; wipe the entry
                    // behind the beam so the next draw into this half starts blank.
                    ram_addr1 = erase_addr_q;
                    ram_we1   = 1'b1;
                    obj_pxl_d = ram_q;
                end else if (pxl_cen) begin
                    if (LHBL) begin
                        erase_d      = 1'b1;
                        erase_addr_d = {bank_q, scan_addr};
                    end else begin
                        // Blank-period pixels show nothing and leave the RAM alone
                        obj_pxl_d = '0;
                    end
                end
            end

            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    jtframe_dual_ram #(
        .AW (AW + 1),
        .DW (DW)
    ) u_ram (
        .clk     (clk),
        .addr0_i (ram_addr0),
        .data0_i (draw.buf_din),
        .we0_i   (ram_we0),
        .addr1_i (ram_addr1),
        .data1_i ('0),
        .we1_i   (ram_we1),
        .q1_o    (ram_q)
    );

    assign line_start = line_start_q;
    assign busy       = (state_q == CLEAR);
    assign obj_pxl    = obj_pxl_q;

endmodule
